// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_if
//  Description : Word handshake and serial-stream bundle between a word
//                producer and the PISO serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             serial_out;
    logic             bit_valid;
    logic             frame_start;
    logic             frame_last;
    logic             busy;
    logic [7:0]       word_count;

    // Producer side: offers words, observes the stream and status.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  serial_out,
        input  bit_valid,
        input  frame_start,
        input  frame_last,
        input  busy,
        input  word_count
    );

    // Serializer side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output serial_out,
        output bit_valid,
        output frame_start,
        output frame_last,
        output busy,
        output word_count
    );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in serial-out shifter, MSB first, with framing
//                strobes and an optional idle gap between words.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int   WIDTH      = 4,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input wire logic          clk,
    input wire logic          rst,
    piso_serializer_if.slave  bus
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam bit                 c_HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [7:0]         c_GAP_LAST = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_gap_cnt;
    logic [7:0]         r_word_count;
    logic               r_serial_out;
    logic               r_bit_valid;
    logic               r_frame_start;
    logic               r_frame_last;
    logic               r_busy;
    logic               r_in_ready;

    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [7:0]         w_gap_cnt_nxt;
    logic [7:0]         w_word_count_nxt;
    logic               w_serial_out_nxt;
    logic               w_bit_valid_nxt;
    logic               w_frame_start_nxt;
    logic               w_frame_last_nxt;
    logic               w_busy_nxt;
    logic               w_in_ready_nxt;
    logic               w_xfer;
    logic               w_last_bit;

    // in_ready is itself a register, so the handshake is decided purely
    // from values that were stable before the edge.
    assign w_xfer     = bus.in_valid & r_in_ready;
    assign w_last_bit = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_cnt_nxt        = r_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_word_count_nxt = r_word_count;

        case (r_state)
            c_ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = c_ST_SHIFT;
                    w_shift_nxt = bus.in_data;
                    w_cnt_nxt   = '0;
                end
            end

            c_ST_SHIFT: begin
                if (w_last_bit) begin
                    w_word_count_nxt = r_word_count + 8'd1;
                    if (c_HAS_GAP) begin
                        w_state_nxt   = c_ST_GAP;
                        w_gap_cnt_nxt = '0;
                    end else if (w_xfer) begin
                        w_state_nxt = c_ST_SHIFT;
                        w_shift_nxt = bus.in_data;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they can be registered
        // without adding a cycle of latency to the stream.
        w_bit_valid_nxt   = (w_state_nxt == c_ST_SHIFT);
        w_serial_out_nxt  = w_bit_valid_nxt ? w_shift_nxt[WIDTH-1] : IDLE_LEVEL;
        w_frame_start_nxt = w_bit_valid_nxt && (w_cnt_nxt == '0);
        w_frame_last_nxt  = w_bit_valid_nxt && (w_cnt_nxt == c_CNT_LAST);
        w_busy_nxt        = (w_state_nxt != c_ST_IDLE);
        w_in_ready_nxt    = (w_state_nxt == c_ST_IDLE) ||
                            (!c_HAS_GAP && w_frame_last_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_gap_cnt     <= '0;
            r_word_count  <= '0;
            r_serial_out  <= IDLE_LEVEL;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_last  <= 1'b0;
            r_busy        <= 1'b0;
            r_in_ready    <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_cnt         <= w_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_word_count  <= w_word_count_nxt;
            r_serial_out  <= w_serial_out_nxt;
            r_bit_valid   <= w_bit_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_frame_last  <= w_frame_last_nxt;
            r_busy        <= w_busy_nxt;
            r_in_ready    <= w_in_ready_nxt;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.serial_out  = r_serial_out;
    assign bus.bit_valid   = r_bit_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_last  = r_frame_last;
    assign bus.busy        = r_busy;
    assign bus.word_count  = r_word_count;

endmodule
`default_nettype wire
